stream_mux_n: RTL

Parametrised N-channel, W-bit stream multiplexer with a registered output stage and valid/ready handshakes on every port. It generalises the datapath 2:1 select mux into a flow-controlled selector. It is used where several producers (forwarding sources, writeback candidates, memory response streams) share one consumer. Selection is either a directly driven channel index or a fair round-robin arbiter, chosen at elaboration time.

---
 rtl/stream_mux_n.sv | 89 ++++++++
 1 files changed

// File: rtl/stream_mux_n.sv
// N-channel valid/ready stream selector with one registered output stage.
// The channel is picked by a direct index (MODE 0) or a round-robin arbiter (MODE 1).
module stream_mux_n #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 32,
    parameter int MODE  = 0,
    parameter int SELW  = (N_CH > 2) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    input  logic [SELW-1:0]       sel,
    output logic [WIDTH-1:0]      out_data,
    output logic [SELW-1:0]       out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam logic [SELW:0] N_CH_W = (SELW+1)'(N_CH);

    logic [N_CH-1:0][WIDTH-1:0] ch_data;
    logic [N_CH-1:0]            gnt_oh;
    logic [SELW-1:0]            gnt;
    logic [SELW-1:0]            ptr;
    logic [WIDTH-1:0]           gnt_data;
    logic                       gnt_vld;
    logic                       load_en;
    logic                       xfer;
    int                         best_d;
    int                         d;

    assign ch_data = in_data;
    assign load_en = !out_valid || out_ready;

    // MODE 1 picks the valid channel at the smallest forward distance from ptr.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        best_d  = N_CH;
        d       = 0;
        if (MODE == 0) begin
            gnt     = sel;
            gnt_vld = ({1'b0, sel} < N_CH_W);
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                d = c - int'(ptr);
                if (d < 0) d = d + N_CH;
                if (in_valid[c] && d < best_d) begin
                    best_d  = d;
                    gnt     = SELW'(c);
                    gnt_vld = 1'b1;
                end
            end
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_lane
        assign gnt_oh[c] = gnt_vld && (gnt == SELW'(c));
    end

    assign in_ready = (rst || !load_en) ? '0 : gnt_oh;
    assign xfer     = |(in_ready & in_valid);

    always_comb begin
        gnt_data = '0;
        for (int c = 0; c < N_CH; c++)
            if (gnt_oh[c]) gnt_data = gnt_data | ch_data[c];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_ch    <= gnt;
            if (MODE == 1)
                ptr <= (gnt == SELW'(N_CH-1)) ? '0 : gnt + SELW'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
